// File: rtl/riscv_dm_regacc_seq.sv
// Sequences Debug Module abstract register accesses: logical reg -> rename lookup -> physical RF access -> response.
// Define RISCV_DM_REGACC_X0_GUARD_EN to answer valid x0 commands directly without touching rename/RF ports.
module riscv_dm_regacc_seq #(
  parameter int unsigned NUM_HARTS     = 1,
  parameter int unsigned NUM_PHYS_REGS = 64,
  localparam int unsigned PHYS_REG_BITS = $clog2(NUM_PHYS_REGS),
  localparam int unsigned HART_BITS     = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1,
  localparam int unsigned XLEN          = 64
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               req_valid_i,
  output logic                               req_ready_o,
  input  logic [HART_BITS-1:0]               req_hart_i,
  input  logic [4:0]                         req_reg_i,
  input  logic                               req_write_i,
  input  logic [XLEN-1:0]                    req_wdata_i,
  output logic                               resp_valid_o,
  input  logic                               resp_ready_i,
  output logic [XLEN-1:0]                    resp_data_o,
  output logic                               resp_err_o,
  output logic                               busy_o,
  input  logic [NUM_HARTS-1:0]               halted_i,
  input  logic [NUM_HARTS-1:0]               unavail_i,
  output logic [NUM_HARTS-1:0]               rnm_read_en_o,
  output logic [NUM_HARTS*5-1:0]             rnm_read_reg_o,
  input  logic [NUM_HARTS*PHYS_REG_BITS-1:0] rnm_read_resp_i,
  output logic [NUM_HARTS-1:0]               rf_en_o,
  output logic [NUM_HARTS*PHYS_REG_BITS-1:0] rf_preg_o,
  input  logic [NUM_HARTS*XLEN-1:0]          rf_rdata_i,
  output logic [NUM_HARTS-1:0]               rf_we_o,
  output logic [NUM_HARTS*XLEN-1:0]          rf_wdata_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_RNM, S_PREG, S_RF, S_RDAT, S_RESP
  } state_e;

  state_e                   state_q, state_d;
  logic [HART_BITS-1:0]     hart_q;
  logic [4:0]               reg_q;
  logic                     write_q;
  logic [XLEN-1:0]          wdata_q;
  logic [PHYS_REG_BITS-1:0] preg_q;
  logic [XLEN-1:0]          data_q;
  logic                     err_q;

  logic                     accept;
  logic                     req_in_range, req_halted, req_unavail, req_ok;
  logic                     x0_skip;
  logic [PHYS_REG_BITS-1:0] sel_preg;
  logic [XLEN-1:0]          sel_rdata;

`ifdef RISCV_DM_REGACC_X0_GUARD_EN
  assign x0_skip = (req_reg_i == 5'd0);
`else
  assign x0_skip = 1'b0;
`endif

  assign accept = req_valid_i && (state_q == S_IDLE);
  assign req_ok = req_in_range && req_halted && !req_unavail;

  // Lane muxes compare against every implemented hart so an out-of-range hart index never indexes past the buses.
  always_comb begin
    req_in_range = 1'b0;
    req_halted   = 1'b0;
    req_unavail  = 1'b0;
    sel_preg     = '0;
    sel_rdata    = '0;
    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      if (req_hart_i == HART_BITS'(h)) begin
        req_in_range = 1'b1;
        req_halted   = halted_i[h];
        req_unavail  = unavail_i[h];
      end
      if (hart_q == HART_BITS'(h)) begin
        sel_preg  = rnm_read_resp_i[h*PHYS_REG_BITS +: PHYS_REG_BITS];
        sel_rdata = rf_rdata_i[h*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (!req_ok || x0_skip) ? S_RESP : S_RNM;
      S_RNM:  state_d = S_PREG;
      S_PREG: state_d = S_RF;
      S_RF:   state_d = write_q ? S_RESP : S_RDAT;
      S_RDAT: state_d = S_RESP;
      S_RESP: if (resp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hart_q  <= '0;
      reg_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      preg_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          hart_q  <= req_hart_i;
          reg_q   <= req_reg_i;
          write_q <= req_write_i;
          wdata_q <= req_wdata_i;
          preg_q  <= '0;
          data_q  <= '0;
          err_q   <= !req_ok;
        end
        S_PREG: preg_q <= sel_preg;
        S_RDAT: data_q <= sel_rdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready_o    = (state_q == S_IDLE);
    busy_o         = (state_q != S_IDLE);
    resp_valid_o   = (state_q == S_RESP);
    resp_data_o    = (state_q == S_RESP) ? data_q : '0;
    resp_err_o     = (state_q == S_RESP) && err_q;
    rnm_read_en_o  = '0;
    rnm_read_reg_o = '0;
    rf_en_o        = '0;
    rf_preg_o      = '0;
    rf_we_o        = '0;
    rf_wdata_o     = '0;
    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      if (hart_q == HART_BITS'(h)) begin
        if (state_q == S_RNM) begin
          rnm_read_en_o[h]        = 1'b1;
          rnm_read_reg_o[h*5 +: 5] = reg_q;
        end
        if (state_q == S_RF) begin
          rf_en_o[h]                                 = 1'b1;
          rf_preg_o[h*PHYS_REG_BITS +: PHYS_REG_BITS] = preg_q;
          rf_we_o[h]                                 = write_q;
          if (write_q) rf_wdata_o[h*XLEN +: XLEN] = wdata_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_riscv_dm_regacc_seq.sv
// Self-checking bench for riscv_dm_regacc_seq (3 harts): directed and random commands against a register-file model.
module tb_riscv_dm_regacc_seq;
  localparam int NH = 3;
  localparam int PB = 6;
  localparam int XL = 64;
`ifdef RISCV_DM_REGACC_X0_GUARD_EN
  localparam bit X0G = 1'b1;
`else
  localparam bit X0G = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err, busy;
  logic [1:0]        req_hart;
  logic [4:0]        req_reg;
  logic [XL-1:0]     req_wdata, resp_data;
  logic [NH-1:0]     halted, unavail, rnm_en, rf_en, rf_we;
  logic [NH*5-1:0]   rnm_reg;
  logic [NH*PB-1:0]  rnm_resp, rf_preg;
  logic [NH*XL-1:0]  rf_rdata, rf_wdata;

  riscv_dm_regacc_seq #(.NUM_HARTS(NH), .NUM_PHYS_REGS(64)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_hart_i(req_hart), .req_reg_i(req_reg), .req_write_i(req_write), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_data_o(resp_data), .resp_err_o(resp_err),
    .busy_o(busy), .halted_i(halted), .unavail_i(unavail),
    .rnm_read_en_o(rnm_en), .rnm_read_reg_o(rnm_reg), .rnm_read_resp_i(rnm_resp),
    .rf_en_o(rf_en), .rf_preg_o(rf_preg), .rf_rdata_i(rf_rdata), .rf_we_o(rf_we), .rf_wdata_o(rf_wdata)
  );

  // Hart-side environment: rename tables and physical register files; garbage when not strobed.
  logic [PB-1:0] rnm_tab [NH][32];
  logic [XL-1:0] env_rf  [NH][64];
  logic [XL-1:0] m_rf    [NH][64];

  always @(posedge clk) begin
    for (int h = 0; h < NH; h++) begin
      if (rnm_en[h] === 1'b1) rnm_resp[h*PB +: PB] <= rnm_tab[h][rnm_reg[h*5 +: 5]];
      else                    rnm_resp[h*PB +: PB] <= PB'($urandom);
      if (rf_en[h] === 1'b1) begin
        if (rf_we[h] === 1'b1) env_rf[h][rf_preg[h*PB +: PB]] = rf_wdata[h*XL +: XL];
        rf_rdata[h*XL +: XL] <= env_rf[h][rf_preg[h*PB +: PB]];
      end else begin
        rf_rdata[h*XL +: XL] <= {$urandom, $urandom};
      end
    end
  end

  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One command: drive, watch every cycle up to a bound, compare to the model, then hold and release the response.
  task automatic do_cmd(input int h, input int r, input bit wr, input logic [XL-1:0] wd,
                        input int stall, input bit perturb);
    bit ok, skip, got, unstable, leak, busy1;
    int exp_lat, lat, rnm_cnt, rnm_cyc, rf_cnt, rf_cyc;
    logic [XL-1:0] exp_data, d0;
    logic e0;
    logic [255:0] s_rnm_en, s_rnm_reg, s_rf_en, s_rf_we, s_rf_preg, s_rf_wdata;
    logic [255:0] e_rnm_en, e_rnm_reg, e_rf_en, e_rf_we, e_rf_preg, e_rf_wdata;
    ok   = (h < NH) ? (halted[h] && !unavail[h]) : 1'b0;
    skip = X0G && (r == 0);
    exp_lat  = (!ok || skip) ? 1 : (wr ? 4 : 5);
    exp_data = (!ok || skip || wr) ? '0 : m_rf[h][rnm_tab[h][r]];
    {e_rnm_en, e_rnm_reg, e_rf_en, e_rf_we, e_rf_preg, e_rf_wdata} = '0;
    if (ok && !skip) begin
      e_rnm_en[h] = 1'b1;
      e_rnm_reg[h*5 +: 5] = 5'(r);
      e_rf_en[h] = 1'b1;
      e_rf_we[h] = wr;
      e_rf_preg[h*PB +: PB] = rnm_tab[h][r];
      if (wr) e_rf_wdata[h*XL +: XL] = wd;
      if (wr) m_rf[h][rnm_tab[h][r]] = wd;
    end
    {s_rnm_en, s_rnm_reg, s_rf_en, s_rf_we, s_rf_preg, s_rf_wdata} = '0;
    {got, unstable, leak, busy1} = '0;
    {lat, rnm_cnt, rnm_cyc, rf_cnt, rf_cyc} = '0;
    d0 = '0; e0 = 1'b0;

    @(negedge clk);
    chk("req_ready_before_accept", 256'(req_ready), 256'(1));
    req_valid = 1'b1; req_hart = 2'(h); req_reg = 5'(r); req_write = wr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_wdata = {$urandom, $urandom};
    if (perturb && h < NH) begin halted[h] = 1'b0; unavail[h] = 1'b1; end
    for (int c = 1; c <= 12 && !got; c++) begin
      @(negedge clk);
      if (c == 1) busy1 = busy;
      if (rnm_en != 0) begin rnm_cnt++; rnm_cyc = c; s_rnm_en = 256'(rnm_en); s_rnm_reg = 256'(rnm_reg); end
      else if (rnm_reg != 0) leak = 1'b1;
      if (rf_en != 0) begin
        rf_cnt++; rf_cyc = c;
        s_rf_en = 256'(rf_en); s_rf_we = 256'(rf_we); s_rf_preg = 256'(rf_preg); s_rf_wdata = 256'(rf_wdata);
      end else if (rf_we != 0 || rf_preg != 0 || rf_wdata != 0) leak = 1'b1;
      if (resp_valid) begin got = 1'b1; lat = c; d0 = resp_data; e0 = resp_err; end
      else if (resp_data != 0 || resp_err != 0) leak = 1'b1;
    end
    chk("busy_after_accept", 256'(busy1), 256'(1));
    chk("latency", 256'(lat), 256'(exp_lat));
    chk("resp_data", 256'(d0), 256'(exp_data));
    chk("resp_err", 256'(e0), 256'(!ok));
    chk("rnm_strobe_count", 256'(rnm_cnt), 256'((ok && !skip) ? 1 : 0));
    chk("rf_strobe_count", 256'(rf_cnt), 256'((ok && !skip) ? 1 : 0));
    chk("idle_lanes_zero", 256'(leak), 256'(0));
    if (ok && !skip) begin
      chk("rnm_cycle", 256'(rnm_cyc), 256'(1));
      chk("rf_cycle", 256'(rf_cyc), 256'(3));
      chk("rnm_en_lanes", s_rnm_en, e_rnm_en);
      chk("rnm_reg_lanes", s_rnm_reg, e_rnm_reg);
      chk("rf_en_lanes", s_rf_en, e_rf_en);
      chk("rf_we_lanes", s_rf_we, e_rf_we);
      chk("rf_preg_lanes", s_rf_preg, e_rf_preg);
      chk("rf_wdata_lanes", s_rf_wdata, e_rf_wdata);
    end
    if (got) begin
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        if (resp_valid !== 1'b1 || resp_data !== d0 || resp_err !== e0 || req_ready !== 1'b0) unstable = 1'b1;
      end
      if (stall > 0) chk("resp_stable_while_stalled", 256'(unstable), 256'(0));
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      @(negedge clk);
      chk("idle_after_handshake", 256'({resp_valid, req_ready, busy}), 256'(3'b010));
    end
  endtask

  initial begin
    bit abort_resp;
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; req_hart = '0; req_reg = '0;
    req_write = 1'b0; req_wdata = '0; halted = '1; unavail = '0;
    for (int h = 0; h < NH; h++) begin
      for (int r = 0; r < 32; r++) rnm_tab[h][r] = PB'($urandom_range(0, 63));
      for (int p = 0; p < 64; p++) begin env_rf[h][p] = {$urandom, $urandom}; m_rf[h][p] = env_rf[h][p]; end
    end
    rnm_tab[0][5] = 6'd17; rnm_tab[0][7] = 6'd9;
    env_rf[0][17] = 64'hDEAD_BEEF; m_rf[0][17] = 64'hDEAD_BEEF;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 256'(req_ready), 256'(1));
    chk("reset_flags", 256'({resp_valid, resp_err, busy}), 256'(0));
    chk("reset_resp_data", 256'(resp_data), 256'(0));
    chk("reset_strobes", 256'({rnm_en, rf_en, rf_we}), 256'(0));
    chk("reset_lane_data", 256'({rnm_reg, rf_preg}) | 256'(rf_wdata), 256'(0));

    do_cmd(0, 5, 1'b0, '0, 0, 1'b0);
    do_cmd(0, 7, 1'b1, 64'h1234, 0, 1'b0);
    do_cmd(0, 7, 1'b0, '0, 1, 1'b0);
    halted[0] = 1'b0;
    do_cmd(0, 5, 1'b0, '0, 0, 1'b0);
    halted[0] = 1'b1;
    do_cmd(1, 10, 1'b0, '0, 0, 1'b0);
    do_cmd(2, 31, 1'b1, {$urandom, $urandom}, 2, 1'b0);
    unavail[1] = 1'b1;
    do_cmd(1, 3, 1'b0, '0, 0, 1'b0);
    unavail[1] = 1'b0;
    do_cmd(3, 4, 1'b0, '0, 0, 1'b0);
    do_cmd(0, 0, 1'b0, '0, 0, 1'b0);
    do_cmd(2, 0, 1'b1, {$urandom, $urandom}, 0, 1'b0);
    do_cmd(1, 0, 1'b0, '0, 0, 1'b0);
    do_cmd(1, 4, 1'b0, '0, 10, 1'b0);
    do_cmd(2, 6, 1'b0, '0, 0, 1'b1);
    halted = '1; unavail = '0;

    // Reset while the RF access strobe is up: the command must vanish without a response.
    @(negedge clk);
    req_valid = 1'b1; req_hart = 2'd1; req_reg = 5'd9; req_write = 1'b0;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_rf_strobe_up", 256'(rf_en), 256'(3'b010));
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", 256'({req_ready, busy, resp_valid}), 256'(3'b100));
    chk("abort_strobes", 256'({rnm_en, rf_en, rf_we}), 256'(0));
    abort_resp = 1'b0;
    repeat (8) begin @(negedge clk); if (resp_valid !== 1'b0) abort_resp = 1'b1; end
    chk("abort_no_resp", 256'(abort_resp), 256'(0));

    for (int i = 0; i < 60; i++) begin
      halted = '1; unavail = '0;
      if ($urandom_range(0, 4) == 0) begin halted = 3'($urandom); unavail = 3'($urandom); end
      do_cmd($urandom_range(0, 3), $urandom_range(0, 31), 1'($urandom), {$urandom, $urandom},
             $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end
endmodule
